// File: rtl/operand_forward_unit_pkg.sv
// Shared definitions for the EX-stage operand forwarding unit.
//   opsel_e     : encoding of the registered EX operand selects
//   TAG_FLAG_W  : flag bits carried with each in-flight destination tag (we, load)
package operand_forward_unit_pkg;

    typedef enum logic [1:0] {
        OPSEL_REG = 2'd0,   // regfile operand (also covers WB, regfile is write-through)
        OPSEL_IMM = 2'd1,   // immediate
        OPSEL_ALU = 2'd2,   // MEM-stage ALU result
        OPSEL_MEM = 2'd3    // MEM-stage load data
    } opsel_e;

    // A destination tag is {rd, we, load}: RADDR_W + TAG_FLAG_W bits.
    localparam int TAG_FLAG_W = 2;

endpackage

// File: rtl/operand_forward_unit_fwd_sel_logic.sv
// Per-operand forwarding priority compare.
//   rs, use_reg          : source index, and whether the operand reads a register
//   ex_* / mem_* / wb_*  : in-flight destination tags of the older instructions
//   sel                  : operand select to be registered for EX
//   load_hazard          : this operand depends on a load whose data is not yet forwardable
module fwd_sel_logic
    import operand_forward_unit_pkg::*;
#(
    parameter int RADDR_W    = 5,
    parameter int LOAD_STALL = 1
) (
    input  logic [RADDR_W-1:0] rs,
    input  logic               use_reg,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               ex_we,
    input  logic               ex_load,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic               mem_we,
    input  logic               mem_load,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic               wb_we,
    output logic [1:0]         sel,
    output logic               load_hazard
);

    // With a two-bubble load-use policy the load data is not taken from MEM,
    // so a load still sitting in MEM is a hazard as well.
    localparam bit MEM_LOAD_STALLS = (LOAD_STALL == 2);

    logic rs_nonzero;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired to zero: it never forwards and never stalls.
    assign rs_nonzero = (rs != '0);
    assign ex_hit     = ex_we  && (ex_rd  == rs) && rs_nonzero;
    assign mem_hit    = mem_we && (mem_rd == rs) && rs_nonzero;
    assign wb_hit     = wb_we  && (wb_rd  == rs) && rs_nonzero;

    always_comb begin
        sel = OPSEL_REG;
        if (!use_reg) begin
            sel = OPSEL_IMM;
        end else if (ex_hit && !ex_load) begin
            sel = OPSEL_ALU;
        end else if (mem_hit) begin
            sel = mem_load ? OPSEL_MEM : OPSEL_ALU;
        end else if (wb_hit) begin
            // Regfile writes through, so a WB producer is read as a normal register.
            sel = OPSEL_REG;
        end
    end

    assign load_hazard = use_reg &&
                         ((ex_hit && ex_load) ||
                          (MEM_LOAD_STALLS && mem_hit && mem_load));

endmodule

// File: rtl/operand_forward_unit.sv
// EX-stage operand forwarding unit.
// Tracks destination tags through EX/MEM/WB, registers the A/B forwarding selects
// computed in ID, raises the load-use stall and drives the EX operand muxes.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   flush                      : squash ID and EX (branch/jump redirect)
//   id_valid, id_rs1, id_rs2   : ID instruction and its sources
//   id_use_rs2                 : 0 selects the immediate for operand B
//   id_rd, id_rd_we, id_is_load: ID destination tag
//   stall                      : combinational load-use stall (hold IF/ID, bubble EX)
//   reg_a, reg_b, imm          : EX regfile operands and immediate
//   alu_fwd, mem_fwd           : MEM-stage ALU result and load data
//   a_sel, b_sel               : registered operand selects
//   a_out, b_out               : EX operands
//   stall_cnt                  : saturating count of stall cycles
module operand_forward_unit
    import operand_forward_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RADDR_W    = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic               id_use_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_rd_we,
    input  logic               id_is_load,
    output logic               stall,
    input  logic [XLEN-1:0]    reg_a,
    input  logic [XLEN-1:0]    reg_b,
    input  logic [XLEN-1:0]    imm,
    input  logic [XLEN-1:0]    alu_fwd,
    input  logic [XLEN-1:0]    mem_fwd,
    output logic [1:0]         a_sel,
    output logic [1:0]         b_sel,
    output logic [XLEN-1:0]    a_out,
    output logic [XLEN-1:0]    b_out,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // In-flight destination tags. WB needs no load flag: it only ever maps to the regfile.
    logic [RADDR_W-1:0] ex_rd;
    logic               ex_we;
    logic               ex_load;
    logic [RADDR_W-1:0] mem_rd;
    logic               mem_we;
    logic               mem_load;
    logic [RADDR_W-1:0] wb_rd;
    logic               wb_we;

    logic [1:0] a_sel_next;
    logic [1:0] b_sel_next;
    logic       a_hazard;
    logic       b_hazard;
    logic       bubble;

    function automatic logic [XLEN-1:0] pick(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] from_reg,
        input logic [XLEN-1:0] from_imm,
        input logic [XLEN-1:0] from_alu,
        input logic [XLEN-1:0] from_mem
    );
        case (sel)
            OPSEL_IMM: pick = from_imm;
            OPSEL_ALU: pick = from_alu;
            OPSEL_MEM: pick = from_mem;
            default:   pick = from_reg;
        endcase
    endfunction

    fwd_sel_logic #(
        .RADDR_W    (RADDR_W),
        .LOAD_STALL (LOAD_STALL)
    ) u_sel_a (
        .rs          (id_rs1),
        .use_reg     (1'b1),
        .ex_rd       (ex_rd),
        .ex_we       (ex_we),
        .ex_load     (ex_load),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .mem_load    (mem_load),
        .wb_rd       (wb_rd),
        .wb_we       (wb_we),
        .sel         (a_sel_next),
        .load_hazard (a_hazard)
    );

    fwd_sel_logic #(
        .RADDR_W    (RADDR_W),
        .LOAD_STALL (LOAD_STALL)
    ) u_sel_b (
        .rs          (id_rs2),
        .use_reg     (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_we       (ex_we),
        .ex_load     (ex_load),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .mem_load    (mem_load),
        .wb_rd       (wb_rd),
        .wb_we       (wb_we),
        .sel         (b_sel_next),
        .load_hazard (b_hazard)
    );

    // Flush squashes the ID instruction, so it also masks the stall. Because the
    // stall depends only on the tag registers, an asynchronous reset drops it at once.
    assign stall  = id_valid && !flush && (a_hazard || b_hazard);
    assign bubble = stall || flush;

    // ---- ID -> EX -> MEM -> WB tag pipeline and registered selects ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd    <= '0;
            ex_we    <= 1'b0;
            ex_load  <= 1'b0;
            mem_rd   <= '0;
            mem_we   <= 1'b0;
            mem_load <= 1'b0;
            wb_rd    <= '0;
            wb_we    <= 1'b0;
            a_sel    <= OPSEL_REG;
            b_sel    <= OPSEL_REG;
        end else begin
            wb_rd    <= mem_rd;
            wb_we    <= mem_we;
            mem_rd   <= ex_rd;
            mem_we   <= ex_we;
            mem_load <= ex_load;
            if (bubble) begin
                ex_rd   <= '0;
                ex_we   <= 1'b0;
                ex_load <= 1'b0;
                a_sel   <= OPSEL_REG;
                b_sel   <= OPSEL_REG;
            end else begin
                ex_rd   <= id_rd;
                ex_we   <= id_rd_we && id_valid;
                ex_load <= id_is_load && id_valid;
                a_sel   <= a_sel_next;
                b_sel   <= b_sel_next;
            end
        end
    end

    // ---- stall performance counter (saturating) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    // ---- EX operand muxes on the registered selects ----
    assign a_out = pick(a_sel, reg_a, imm, alu_fwd, mem_fwd);
    assign b_out = pick(b_sel, reg_b, imm, alu_fwd, mem_fwd);

endmodule

// File: tb/tb_operand_forward_unit.sv
// Bench for operand_forward_unit: two instances (one- and two-bubble load-use policy,
// the second with a narrow counter) driven with the same ID stream, compared against
// an instruction-level reference model.
module tb_operand_forward_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic        id_is_load;
    logic [31:0] reg_a, reg_b, imm, alu_fwd, mem_fwd;

    logic        stall1, stall2;
    logic [1:0]  a_sel1, b_sel1, a_sel2, b_sel2;
    logic [31:0] a_out1, b_out1, a_out2, b_out2;
    logic [15:0] cnt1;
    logic [2:0]  cnt2;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    operand_forward_unit #(.XLEN(32), .RADDR_W(5), .LOAD_STALL(1), .CNT_W(16)) u_ls1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_rd_we(id_rd_we), .id_is_load(id_is_load), .stall(stall1),
        .reg_a(reg_a), .reg_b(reg_b), .imm(imm), .alu_fwd(alu_fwd), .mem_fwd(mem_fwd),
        .a_sel(a_sel1), .b_sel(b_sel1), .a_out(a_out1), .b_out(b_out1), .stall_cnt(cnt1)
    );

    operand_forward_unit #(.XLEN(32), .RADDR_W(5), .LOAD_STALL(2), .CNT_W(3)) u_ls2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_rd_we(id_rd_we), .id_is_load(id_is_load), .stall(stall2),
        .reg_a(reg_a), .reg_b(reg_b), .imm(imm), .alu_fwd(alu_fwd), .mem_fwd(mem_fwd),
        .a_sel(a_sel2), .b_sel(b_sel2), .a_out(a_out2), .b_out(b_out2), .stall_cnt(cnt2)
    );

    // ---------------- reference model ----------------
    // Per instance: the instruction now in EX and the one now in MEM, the operand
    // source chosen for the instruction in EX, and the number of stall cycles.
    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic       load;
    } instr_t;

    instr_t      m_ex [2];
    instr_t      m_mem[2];
    logic [1:0]  m_as [2];
    logic [1:0]  m_bs [2];
    int          m_cnt[2];
    int          bubbles [2] = '{1, 2};
    int          cnt_max [2] = '{65535, 7};

    function automatic bit writes(instr_t t, logic [4:0] rs);
        return t.we && (t.rd == rs) && (rs != 5'd0);
    endfunction

    // Load result not yet reachable: load in EX, or (two-bubble policy) load in MEM.
    function automatic bit waits_on_load(int i, logic [4:0] rs);
        return (m_ex[i].load && writes(m_ex[i], rs)) ||
               (bubbles[i] == 2 && m_mem[i].load && writes(m_mem[i], rs));
    endfunction

    function automatic bit model_stall(int i);
        if (!id_valid || flush) return 1'b0;
        return waits_on_load(i, id_rs1) || (id_use_rs2 && waits_on_load(i, id_rs2));
    endfunction

    function automatic logic [1:0] source_of(int i, logic [4:0] rs);
        if (writes(m_ex[i], rs) && !m_ex[i].load) return 2'd2;
        if (writes(m_mem[i], rs)) return m_mem[i].load ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] operand(logic [1:0] sel);
        case (sel)
            2'd1:    return imm;
            2'd2:    return alu_fwd;
            2'd3:    return mem_fwd;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ex[i]  = '0;
            m_mem[i] = '0;
            m_as[i]  = 2'd0;
            m_bs[i]  = 2'd0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit         s;
            logic [1:0] na, nb;
            s  = model_stall(i);
            na = source_of(i, id_rs1);
            nb = id_use_rs2 ? source_of(i, id_rs2) : 2'd1;
            if (s || flush) begin
                na = 2'd0;
                nb = 2'd0;
            end
            m_mem[i] = m_ex[i];
            if (s || flush) m_ex[i] = '0;
            else m_ex[i] = '{rd: id_rd, we: id_rd_we && id_valid, load: id_is_load && id_valid};
            m_as[i] = na;
            m_bs[i] = nb;
            if (s && m_cnt[i] < cnt_max[i]) m_cnt[i]++;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are already applied; check the combinational stall, clock once,
    // then check the registered selects, the operand muxes and the counters.
    task automatic cycle();
        logic [31:0] ea0, eb0, ea1, eb1;
        #1;
        check("stall_ls1", stall1, model_stall(0));
        check("stall_ls2", stall2, model_stall(1));
        @(posedge clk);
        model_edge();
        #1;
        ea0 = (m_as[0] == 2'd0) ? reg_a : operand(m_as[0]);
        eb0 = (m_bs[0] == 2'd0) ? reg_b : operand(m_bs[0]);
        ea1 = (m_as[1] == 2'd0) ? reg_a : operand(m_as[1]);
        eb1 = (m_bs[1] == 2'd0) ? reg_b : operand(m_bs[1]);
        check("a_sel_ls1", a_sel1, m_as[0]);
        check("b_sel_ls1", b_sel1, m_bs[0]);
        check("a_out_ls1", a_out1, ea0);
        check("b_out_ls1", b_out1, eb0);
        check("cnt_ls1",   cnt1,   m_cnt[0]);
        check("a_sel_ls2", a_sel2, m_as[1]);
        check("b_sel_ls2", b_sel2, m_bs[1]);
        check("a_out_ls2", a_out2, ea1);
        check("b_out_ls2", b_out2, eb1);
        check("cnt_ls2",   cnt2,   m_cnt[1]);
    endtask

    task automatic set_id(bit v, int rs1, int rs2, bit u2, int rd, bit we, bit ld, bit fl);
        id_valid   = v;
        id_rs1     = 5'(rs1);
        id_rs2     = 5'(rs2);
        id_use_rs2 = u2;
        id_rd      = 5'(rd);
        id_rd_we   = we;
        id_is_load = ld;
        flush      = fl;
    endtask

    task automatic issue(bit v, int rs1, int rs2, bit u2, int rd, bit we, bit ld, bit fl);
        set_id(v, rs1, rs2, u2, rd, we, ld, fl);
        cycle();
    endtask

    task automatic nop();
        issue(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        set_id(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        reg_a   = 32'h1111_1111;
        reg_b   = 32'h2222_2222;
        imm     = 32'h0;
        alu_fwd = 32'hA1A1_0005;
        mem_fwd = 32'hDEAD_BEEF;
        model_reset();

        // reset state
        #12;
        check("rst_stall_ls1", stall1, 1'b0);
        check("rst_stall_ls2", stall2, 1'b0);
        check("rst_a_sel",     a_sel1, 2'd0);
        check("rst_b_sel",     b_sel2, 2'd0);
        check("rst_a_out",     a_out1, 32'h1111_1111);
        check("rst_b_out",     b_out2, 32'h2222_2222);
        check("rst_cnt_ls1",   cnt1,   16'd0);
        check("rst_cnt_ls2",   cnt2,   3'd0);
        rst_n = 1'b1;

        // add x5,x1,x2 ; add x6,x5,x1 -> forward ALU result
        issue(1'b1, 1, 2, 1'b1, 5, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 5, 1, 1'b1, 6, 1'b1, 1'b0, 1'b0);
        check("b2b_a_sel", a_sel1, 2'd2);
        check("b2b_a_out", a_out2, 32'hA1A1_0005);
        nop();
        nop();

        // add x5 ; nop ; sub x7,x5,x5 -> both from MEM ALU result
        issue(1'b1, 1, 2, 1'b1, 5, 1'b1, 1'b0, 1'b0);
        nop();
        issue(1'b1, 5, 5, 1'b1, 7, 1'b1, 1'b0, 1'b0);
        check("gap_a_sel", a_sel1, 2'd2);
        check("gap_b_sel", b_sel2, 2'd2);
        nop();
        nop();

        // lw x8 ; add x9,x8,x0 held in ID while stalled
        issue(1'b1, 2, 0, 1'b0, 8, 1'b1, 1'b1, 1'b0);
        issue(1'b1, 8, 0, 1'b1, 9, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 8, 0, 1'b1, 9, 1'b1, 1'b0, 1'b0);
        check("lu1_a_sel", a_sel1, 2'd3);
        check("lu1_a_out", a_out1, 32'hDEAD_BEEF);
        check("lu1_cnt",   cnt1,   16'd1);
        check("lu2_cnt",   cnt2,   3'd2);
        issue(1'b1, 8, 0, 1'b1, 9, 1'b1, 1'b0, 1'b0);
        check("lu2_a_sel", a_sel2, 2'd0);
        nop();
        nop();

        // addi x0 ; add x1,x0,x0 ; addi x3,x2,5
        issue(1'b1, 1, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 0, 0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        check("x0_a_sel", a_sel1, 2'd0);
        check("x0_b_sel", b_sel1, 2'd0);
        imm = 32'd5;
        issue(1'b1, 2, 0, 1'b0, 3, 1'b1, 1'b0, 1'b0);
        check("imm_b_sel", b_sel2, 2'd1);
        check("imm_b_out", b_out1, 32'd5);
        nop();
        nop();

        // lw x8 then flush with a dependent in ID
        issue(1'b1, 2, 0, 1'b0, 8, 1'b1, 1'b1, 1'b0);
        issue(1'b1, 8, 8, 1'b1, 9, 1'b1, 1'b0, 1'b1);
        check("flush_a_sel", a_sel1, 2'd0);
        check("flush_b_sel", b_sel2, 2'd0);
        nop();
        nop();

        // drive the narrow counter into saturation
        for (int k = 0; k < 4; k++) begin
            issue(1'b1, 2, 0, 1'b0, 8, 1'b1, 1'b1, 1'b0);
            for (int h = 0; h < 3; h++) issue(1'b1, 8, 0, 1'b1, 9, 1'b1, 1'b0, 1'b0);
            nop();
        end
        check("sat_cnt_ls2", cnt2, 3'd7);

        // randomized ID stream
        for (int n = 0; n < 400; n++) begin
            reg_a   = $urandom;
            reg_b   = $urandom;
            imm     = $urandom;
            alu_fwd = $urandom;
            mem_fwd = $urandom;
            issue(($urandom_range(7) != 0), $urandom_range(7), $urandom_range(7),
                  $urandom_range(1), $urandom_range(7), ($urandom_range(3) != 0),
                  ($urandom_range(2) == 0), ($urandom_range(7) == 0));
        end
        nop();
        nop();

        // reset while a load-use stall is pending
        issue(1'b1, 2, 0, 1'b0, 8, 1'b1, 1'b1, 1'b0);
        set_id(1'b1, 8, 0, 1'b1, 9, 1'b1, 1'b0, 1'b0);
        #1;
        check("pre_rst_stall_ls1", stall1, 1'b1);
        check("pre_rst_stall_ls2", stall2, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_stall_ls1", stall1, 1'b0);
        check("midrst_stall_ls2", stall2, 1'b0);
        check("midrst_cnt_ls1",   cnt1,   16'd0);
        check("midrst_cnt_ls2",   cnt2,   3'd0);
        model_reset();
        #4;
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
